// File: rtl/avalon_fp_mult_queue.sv
// Avalon-MM slave feeding an external pipelined FP32 multiplier core.
// Credit-limited issue keeps every in-flight product a guaranteed slot in the in-order result FIFO.
module avalon_fp_mult_queue_chk (
  input logic clk,
  input logic rst_n,
  input logic capture,
  input logic pop,
  input logic full
);
  // a capture into a full FIFO without a same-cycle pop would drop a product
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(capture && !pop && full));
endmodule

module avalon_fp_mult_queue #(
  parameter int DEPTH   = 8,
  parameter int LATENCY = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  avs_s1_address,
  input  logic        avs_s1_read,
  input  logic        avs_s1_write,
  input  logic [31:0] avs_s1_writedata,
  output logic [31:0] avs_s1_readdata,
  output logic        avs_s1_waitrequest,
  output logic        irq,
  output logic [31:0] core_dataa,
  output logic [31:0] core_datab,
  input  logic [31:0] core_result,
  input  logic [3:0]  core_flags
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] ID_VAL = {8'hFA, 8'(LATENCY), 16'(DEPTH)};

  logic [31:0]        op_a_q, op_a_d, op_b_q, op_b_d, rdata_q, rdata_d;
  logic [31:0]        core_a_q, core_a_d, core_b_q, core_b_d;
  logic [4:0]         sticky_q, sticky_d;
  logic               irq_en_q, irq_en_d, irq_q, irq_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [CW-1:0]      inflight_q, inflight_d, count_q, count_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [35:0]        fifo_q [DEPTH];
  logic [35:0]        fifo_d [DEPTH];
  logic [35:0]        head_s;
  logic rd_s, wr_s, credit_s, issue_s, flush_s, pop_s, underrun_s, capture_s, empty_s, full_s;

  // a write coinciding with a read is dropped, so only wr_s qualifies write side effects
  assign rd_s       = avs_s1_read;
  assign wr_s       = avs_s1_write & ~avs_s1_read;
  assign credit_s   = ({1'b0, inflight_q} + {1'b0, count_q}) < (CW+1)'(DEPTH);
  assign issue_s    = wr_s & (avs_s1_address == 3'd1) & credit_s;
  assign flush_s    = wr_s & (avs_s1_address == 3'd2) & avs_s1_writedata[1];
  assign empty_s    = (count_q == {CW{1'b0}});
  assign full_s     = (count_q == CW'(DEPTH));
  assign pop_s      = rd_s & (avs_s1_address == 3'd3) & ~empty_s;
  assign underrun_s = rd_s & (avs_s1_address == 3'd3) & empty_s;
  assign capture_s  = vld_q[LATENCY-1] & ~flush_s;
  assign head_s     = fifo_q[rd_ptr_q];

  assign avs_s1_waitrequest = wr_s & (avs_s1_address == 3'd1) & ~credit_s;
  assign avs_s1_readdata    = rdata_q;
  assign irq                = irq_q;
  assign core_dataa         = core_a_q;
  assign core_datab         = core_b_q;

  // next-state logic for registers, issue pipe, and FIFO
  always_comb begin
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    core_a_d = core_a_q;
    core_b_d = core_b_q;
    irq_en_d = irq_en_q;
    irq_d    = irq_en_q & ~empty_s;
    rdata_d  = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      fifo_d[i] = fifo_q[i];
    end

    if (wr_s && (avs_s1_address == 3'd0)) begin
      op_a_d = avs_s1_writedata;
    end else begin
      op_a_d = op_a_q;
    end
    if (issue_s) begin
      op_b_d   = avs_s1_writedata;
      core_a_d = op_a_q;
      core_b_d = avs_s1_writedata;
    end else begin
      op_b_d   = op_b_q;
    end
    if (wr_s && (avs_s1_address == 3'd6)) begin
      irq_en_d = avs_s1_writedata[0];
    end else begin
      irq_en_d = irq_en_q;
    end

    // flush drops queued results and every product still in the core
    if (flush_s) begin
      vld_d      = {LATENCY{1'b0}};
      inflight_d = {CW{1'b0}};
      count_d    = {CW{1'b0}};
      wr_ptr_d   = {AW{1'b0}};
      rd_ptr_d   = {AW{1'b0}};
    end else begin
      vld_d      = LATENCY'({vld_q, issue_s});
      inflight_d = inflight_q + CW'(issue_s) - CW'(vld_q[LATENCY-1]);
      count_d    = count_q + CW'(capture_s) - CW'(pop_s);
      wr_ptr_d   = wr_ptr_q + AW'(capture_s);
      rd_ptr_d   = rd_ptr_q + AW'(pop_s);
    end
    if (capture_s) begin
      fifo_d[wr_ptr_q] = {core_flags, core_result};
    end else begin
      fifo_d[wr_ptr_q] = fifo_q[wr_ptr_q];
    end

    if (wr_s && (avs_s1_address == 3'd2) && avs_s1_writedata[0]) begin
      sticky_d = 5'd0;
    end else if (wr_s && (avs_s1_address == 3'd5)) begin
      sticky_d = sticky_q & ~avs_s1_writedata[4:0];
    end else if (pop_s) begin
      sticky_d = sticky_q | {1'b0, head_s[35:32]};
    end else if (underrun_s) begin
      sticky_d = sticky_q | 5'b10000;
    end else begin
      sticky_d = sticky_q;
    end

    if (rd_s) begin
      case (avs_s1_address)
        3'd0:    rdata_d = op_a_q;
        3'd1:    rdata_d = op_b_q;
        3'd2:    rdata_d = {16'd0, 8'(inflight_q), 8'(count_q)};
        3'd3:    rdata_d = empty_s ? 32'd0 : head_s[31:0];
        3'd4:    rdata_d = empty_s ? 32'd0 : {28'd0, head_s[35:32]};
        3'd5:    rdata_d = {27'd0, sticky_q};
        3'd6:    rdata_d = {31'd0, irq_en_q};
        3'd7:    rdata_d = ID_VAL;
        default: rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = 32'd0;
    end
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a_q     <= 32'd0;
      op_b_q     <= 32'd0;
      rdata_q    <= 32'd0;
      core_a_q   <= 32'd0;
      core_b_q   <= 32'd0;
      sticky_q   <= 5'd0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      vld_q      <= {LATENCY{1'b0}};
      inflight_q <= {CW{1'b0}};
      count_q    <= {CW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= 36'd0;
      end
    end else begin
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      rdata_q    <= rdata_d;
      core_a_q   <= core_a_d;
      core_b_q   <= core_b_d;
      sticky_q   <= sticky_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

  avalon_fp_mult_queue_chk u_chk (
    .clk     (clk),
    .rst_n   (reset),
    .capture (capture_s),
    .pop     (pop_s),
    .full    (full_s)
  );
endmodule

// File: tb/tb_avalon_fp_mult_queue.sv
// Bench for avalon_fp_mult_queue: a transaction-level queue model checked every cycle,
// a stub multiplier core of fixed latency, and directed scenarios with literal expectations.
module tb_avalon_fp_mult_queue;
  localparam int DEPTH   = 8;
  localparam int LATENCY = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  avs_address = 3'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic        irq;
  logic [31:0] core_dataa, core_datab, core_result;
  logic [3:0]  core_flags;

  int n_vec = 0;
  int n_err = 0;

  avalon_fp_mult_queue #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk                (clk),
    .reset              (rst_n),
    .avs_s1_address     (avs_address),
    .avs_s1_read        (avs_read),
    .avs_s1_write       (avs_write),
    .avs_s1_writedata   (avs_writedata),
    .avs_s1_readdata    (avs_readdata),
    .avs_s1_waitrequest (avs_waitrequest),
    .irq                (irq),
    .core_dataa         (core_dataa),
    .core_datab         (core_datab),
    .core_result        (core_result),
    .core_flags         (core_flags)
  );

  always #5 clk = ~clk;

  // stub core: known FP products for the directed pairs, an arbitrary mix otherwise
  function automatic logic [35:0] core_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40000000 && b == 32'h40400000) return {4'h0, 32'h40C00000};
    else if (a == 32'h7F000000 && b == 32'h7F000000) return {4'h8, 32'h7F800000};
    else return {a[3:0] ^ b[3:0], a ^ {b[15:0], b[31:16]}};
  endfunction

  logic [35:0] cpipe [LATENCY-1];
  always @(posedge clk) begin
    cpipe[0] <= core_fn(core_dataa, core_datab);
    for (int i = 1; i < LATENCY - 1; i++) cpipe[i] <= cpipe[i-1];
  end
  assign core_result = cpipe[LATENCY-2][31:0];
  assign core_flags  = cpipe[LATENCY-2][35:32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [35:0] d; int due; } inf_t;
  inf_t        m_inf[$];
  logic [35:0] m_fifo[$];
  logic [31:0] m_opa = 32'd0, m_opb = 32'd0, m_ca = 32'd0, m_cb = 32'd0, m_exp_rd = 32'd0;
  logic [4:0]  m_sticky = 5'd0;
  logic        m_irq_en = 1'b0, m_exp_irq = 1'b0, m_rd_pending = 1'b0;
  int          cyc = 0;

  initial forever begin
    int pre_inf, pre_cnt;
    logic rd, wr, cap;
    logic [35:0] capd;
    inf_t ent;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_inf.delete(); m_fifo.delete();
      m_opa = 32'd0; m_opb = 32'd0; m_ca = 32'd0; m_cb = 32'd0; m_exp_rd = 32'd0;
      m_sticky = 5'd0; m_irq_en = 1'b0; m_exp_irq = 1'b0; m_rd_pending = 1'b0;
    end else begin
      cyc++;
      pre_inf = m_inf.size();
      pre_cnt = m_fifo.size();
      rd = avs_read;
      wr = avs_write && !avs_read;
      m_rd_pending = rd;
      if (rd) begin
        case (avs_address)
          3'd0: m_exp_rd = m_opa;
          3'd1: m_exp_rd = m_opb;
          3'd2: m_exp_rd = {16'd0, 8'(pre_inf), 8'(pre_cnt)};
          3'd3: m_exp_rd = (pre_cnt > 0) ? m_fifo[0][31:0] : 32'd0;
          3'd4: m_exp_rd = (pre_cnt > 0) ? {28'd0, m_fifo[0][35:32]} : 32'd0;
          3'd5: m_exp_rd = {27'd0, m_sticky};
          3'd6: m_exp_rd = {31'd0, m_irq_en};
          default: m_exp_rd = 32'hFA0B0008;
        endcase
      end
      m_exp_irq = m_irq_en && (pre_cnt != 0);
      cap = (m_inf.size() > 0) && (m_inf[0].due == cyc);
      if (wr && avs_address == 3'd2 && avs_writedata[1]) begin
        m_inf.delete(); m_fifo.delete();
      end else begin
        capd = 36'd0;
        if (cap) begin capd = m_inf[0].d; void'(m_inf.pop_front()); end
        if (rd && avs_address == 3'd3) begin
          if (pre_cnt > 0) begin
            m_sticky = m_sticky | {1'b0, m_fifo[0][35:32]};
            void'(m_fifo.pop_front());
          end else m_sticky[4] = 1'b1;
        end
        if (cap) m_fifo.push_back(capd);
      end
      if (wr) begin
        case (avs_address)
          3'd0: m_opa = avs_writedata;
          3'd1: if (pre_inf + pre_cnt < DEPTH) begin
                  ent.d = core_fn(m_opa, avs_writedata);
                  ent.due = cyc + LATENCY;
                  m_inf.push_back(ent);
                  m_opb = avs_writedata; m_ca = m_opa; m_cb = avs_writedata;
                end
          3'd2: if (avs_writedata[0]) m_sticky = 5'd0;
          3'd5: m_sticky = m_sticky & ~avs_writedata[4:0];
          3'd6: m_irq_en = avs_writedata[0];
          default: ;
        endcase
      end
    end
  end

  // ---------------- compare process ----------------
  initial forever begin
    logic exp_wait;
    @(negedge clk);
    if (rst_n) begin
      exp_wait = avs_write && !avs_read && (avs_address == 3'd1) &&
                 (m_inf.size() + m_fifo.size() >= DEPTH);
      check("waitrequest", {31'd0, avs_waitrequest}, {31'd0, exp_wait});
      check("irq", {31'd0, irq}, {31'd0, m_exp_irq});
      check("core_dataa", core_dataa, m_ca);
      check("core_datab", core_datab, m_cb);
      if (m_rd_pending) check("readdata", avs_readdata, m_exp_rd);
    end
  end

  // ---------------- bus tasks (called at posedge+1) ----------------
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, output int stalls);
    logic w;
    avs_address = a; avs_writedata = d; avs_write = 1'b1; stalls = 0;
    while (1) begin
      @(negedge clk); w = avs_waitrequest;
      @(posedge clk); #1;
      if (!w) break;
      stalls++;
      if (stalls > 200) begin
        n_vec++; n_err++;
        $display("FAIL write_timeout: addr %0d still stalled after %0d cycles", a, stalls);
        break;
      end
    end
    avs_write = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    int s;
    bus_write(a, d, s);
  endtask

  task automatic rd_expect(input string name, input logic [2:0] a, input logic [31:0] exp);
    avs_address = a; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    check(name, avs_readdata, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a [DEPTH+1];
    logic [31:0] b [DEPTH+1];
    logic [35:0] first;
    int s;
    repeat (2) @(negedge clk);
    check("rst_readdata", avs_readdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_wait", {31'd0, avs_waitrequest}, 32'd0);
    check("rst_core_a", core_dataa, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(1);

    rd_expect("id", 3'd7, 32'hFA0B0008);
    rd_expect("ctrl_reset", 3'd2, 32'd0);

    // single op
    wr(3'd0, 32'h40000000);
    wr(3'd1, 32'h40400000);
    idle(LATENCY + 1);
    rd_expect("single_count", 3'd2, 32'h00000001);
    rd_expect("single_flags", 3'd4, 32'd0);
    rd_expect("single_result", 3'd3, 32'h40C00000);

    // overflow flag and sticky
    wr(3'd0, 32'h7F000000);
    wr(3'd1, 32'h7F000000);
    idle(LATENCY + 1);
    rd_expect("ovf_flags", 3'd4, 32'h00000008);
    rd_expect("ovf_result", 3'd3, 32'h7F800000);
    rd_expect("ovf_sticky", 3'd5, 32'h00000008);
    wr(3'd2, 32'h00000001);
    rd_expect("sticky_clear", 3'd5, 32'd0);

    // empty pop
    rd_expect("empty_pop", 3'd3, 32'd0);
    rd_expect("underrun", 3'd5, 32'h00000010);
    rd_expect("empty_count", 3'd2, 32'd0);
    wr(3'd5, 32'h00000010);
    rd_expect("w1c", 3'd5, 32'd0);

    // burst of DEPTH+1
    for (int i = 0; i <= DEPTH; i++) begin
      a[i] = 32'h3F800000 + i;
      b[i] = 32'h00010000 * (i + 3);
    end
    for (int i = 0; i < DEPTH; i++) begin
      wr(3'd0, a[i]);
      wr(3'd1, b[i]);
    end
    wr(3'd0, a[DEPTH]);
    avs_address = 3'd1; avs_writedata = b[DEPTH]; avs_write = 1'b1;
    repeat (LATENCY + 4) begin
      @(negedge clk);
      check("burst_stall", {31'd0, avs_waitrequest}, 32'd1);
    end
    @(posedge clk); #1; avs_write = 1'b0;
    rd_expect("burst_full", 3'd2, {16'd0, 8'd0, 8'(DEPTH)});
    first = core_fn(a[0], b[0]);
    rd_expect("burst_first", 3'd3, first[31:0]);
    bus_write(3'd1, b[DEPTH], s);
    check("burst_release", s, 32'd0);
    idle(LATENCY + 2);
    for (int i = 1; i <= DEPTH; i++) begin
      first = core_fn(a[i], b[i]);
      rd_expect("burst_order", 3'd3, first[31:0]);
    end
    rd_expect("burst_drained", 3'd2, 32'd0);

    // flush mid-flight
    wr(3'd0, 32'h12345678);
    wr(3'd1, 32'h00000001);
    wr(3'd1, 32'h00000002);
    wr(3'd1, 32'h00000003);
    idle(1);
    wr(3'd2, 32'h00000002);
    idle(LATENCY + 3);
    rd_expect("flush_ctrl", 3'd2, 32'd0);

    // irq then async reset mid-burst
    wr(3'd6, 32'h00000001);
    wr(3'd0, 32'h40000000);
    wr(3'd1, 32'h40400000);
    idle(LATENCY + 2);
    @(negedge clk);
    check("irq_set", {31'd0, irq}, 32'd1);
    @(posedge clk); #1;
    wr(3'd1, 32'h00000005);
    wr(3'd1, 32'h00000006);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_core_a", core_dataa, 32'd0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    idle(1);
    rd_expect("reset_count", 3'd2, 32'd0);
    rd_expect("reset_irqen", 3'd6, 32'd0);
    idle(LATENCY + 3);
    rd_expect("reset_no_late", 3'd2, 32'd0);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
